mac_layer_seq: RTL

MAC_LAYER_SEQ -- requirements
Module: mac_layer_seq

---
 rtl/mac_layer_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mac_layer_seq.sv
// mac_layer_seq: sequences one fully connected layer through an external
// MAC, then shifts, saturates and hands each neuron result downstream.
`timescale 1ns/1ps
module mac_layer_seq #(
  parameter int IN_W    = 10,
  parameter int NEU_W   = 8,
  parameter int WADDR_W = 17
) (
  input  logic               CLKEXT,
  input  logic               RSTN,
  input  logic               START,
  input  logic [IN_W-1:0]    NUM_IN,
  input  logic [NEU_W-1:0]   NUM_NEU,
  input  logic [3:0]         SHIFT,
  input  logic               RELU_EN,
  output logic [IN_W-1:0]    ADDR_X,
  output logic [WADDR_W-1:0] ADDR_W,
  output logic [NEU_W-1:0]   ADDR_B,
  output logic               MAC_EN,
  output logic               MAC_CLR,
  input  logic [15:0]        MAC_RESULT,
  output logic [7:0]         OUT_DATA,
  output logic [NEU_W-1:0]   OUT_IDX,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    WAIT,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [IN_W-1:0]    num_in_q;
  logic [IN_W-1:0]    addr_x_q;
  logic [NEU_W-1:0]   num_neu_q;
  logic [NEU_W-1:0]   neu_q;
  logic [3:0]         shift_q;
  logic               relu_q;
  logic [WADDR_W-1:0] addr_w_q;
  logic [7:0]         data_q;
  logic [NEU_W-1:0]   idx_q;
  logic               done_q;

  logic               last_neu;
  logic               acc_last;
  logic signed [15:0] shifted;
  logic [7:0]         sat;

  assign last_neu = (neu_q + NEU_W'(1)) == num_neu_q;
  // address runs one ahead of MAC_EN, so ACC ends once it reaches NUM_IN
  assign acc_last = addr_x_q == num_in_q;

  always_ff @(posedge CLKEXT or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MAC_EN    = 1'b0;
    MAC_CLR   = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && (NUM_NEU != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        MAC_CLR   = 1'b1;
        state_nxt = (num_in_q != '0) ? ACC : WAIT;
      end
      ACC: begin
        MAC_EN = 1'b1;
        if (acc_last) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (OUT_READY) state_nxt = last_neu ? IDLE : LOAD;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLKEXT or negedge RSTN) begin
    if (!RSTN) begin
      num_in_q  <= '0;
      num_neu_q <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      neu_q     <= '0;
      addr_x_q  <= '0;
      addr_w_q  <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            num_in_q  <= NUM_IN;
            num_neu_q <= NUM_NEU;
            shift_q   <= SHIFT;
            relu_q    <= RELU_EN;
            neu_q     <= '0;
            addr_x_q  <= '0;
            addr_w_q  <= '0;
            done_q    <= (NUM_NEU == '0);
          end
        end
        LOAD: begin
          if (num_in_q != '0) begin
            addr_x_q <= addr_x_q + IN_W'(1);
            addr_w_q <= addr_w_q + WADDR_W'(1);
          end
        end
        ACC: begin
          if (!acc_last) begin
            addr_x_q <= addr_x_q + IN_W'(1);
            addr_w_q <= addr_w_q + WADDR_W'(1);
          end
        end
        WAIT: begin
          data_q <= sat;
          idx_q  <= neu_q;
        end
        OUT: begin
          if (OUT_READY) begin
            addr_x_q <= '0;
            if (last_neu) done_q <= 1'b1;
            else neu_q <= neu_q + NEU_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign shifted = $signed(MAC_RESULT) >>> shift_q;

  always_comb begin
    sat = shifted[7:0];
    if (relu_q) begin
      if (shifted < 16'sd0) sat = 8'h00;
      else if (shifted > 16'sd255) sat = 8'hFF;
    end else begin
      if (shifted < -16'sd128) sat = 8'h80;
      else if (shifted > 16'sd127) sat = 8'h7F;
    end
  end

  assign ADDR_X    = addr_x_q;
  assign ADDR_W    = addr_w_q;
  assign ADDR_B    = neu_q;
  assign OUT_DATA  = data_q;
  assign OUT_IDX   = idx_q;
  assign OUT_VALID = (state == OUT);
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;

endmodule
